// File: rtl/pipe_pkg.sv
// Shared defaults and sizing helpers for the bubble-collapsing pipeline chain.
package pipe_pkg;
  localparam int DEF_WIDTH  = 32;
  localparam int DEF_STAGES = 4;
  localparam int DEF_CNT_W  = 16;

  function automatic int occ_w(input int stages);
    return $clog2(stages + 1);
  endfunction
endpackage

// File: rtl/pipe_chain_if.sv
// Upstream/downstream valid-ready handshake bundle; slave is the chain side.
interface pipe_chain_if
  import pipe_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;

  modport master (output in_valid, in_data, out_ready,
                  input  in_ready, out_valid, out_data);
  modport slave  (input  in_valid, in_data, out_ready,
                  output in_ready, out_valid, out_data);
endinterface

// File: rtl/pipe_stage.sv
// One pipeline slot: valid bit with async clear plus an unreset payload register.
// Loads on load_i, otherwise holds.
module pipe_stage
  import pipe_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load_i,
  input  logic             v_i,
  input  logic [WIDTH-1:0] d_i,
  output logic             v_o,
  output logic [WIDTH-1:0] d_o
);
  logic             v_q;
  logic             v_d;
  logic [WIDTH-1:0] d_q;

  assign v_d = load_i ? v_i : v_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) v_q <= 1'b0;
    else        v_q <= v_d;
  end

  // Payload carries no reset; it is only observed through v.
  always_ff @(posedge clk) begin
    if (load_i) d_q <= d_i;
  end

  assign v_o = v_q;
  assign d_o = d_q;
endmodule

// File: rtl/pipe_chain.sv
// STAGES-deep bubble-collapsing register chain with per-stage flush; latency STAGES cycles.
// Backpressure: a stage advances when any stage at or after it is empty or out_ready is high.
module pipe_chain
  import pipe_pkg::*;
#(
  parameter int WIDTH  = DEF_WIDTH,
  parameter int STAGES = DEF_STAGES,
  parameter int CNT_W  = DEF_CNT_W
) (
  input  logic                         clk,
  input  logic                         rst_n,
  pipe_chain_if.slave                  bus,
  input  logic [STAGES-1:0]            flush_mask,
  output logic [occ_w(STAGES)-1:0]     occupancy,
  output logic [CNT_W-1:0]             stall_cnt
);
  localparam int OCC_W = occ_w(STAGES);

  logic [STAGES-1:0] v_q;
  logic [STAGES-1:0] v_d;
  logic [STAGES-1:0] live;
  logic [STAGES-1:0] adv;
  logic [WIDTH-1:0]  d_q [STAGES];
  logic [WIDTH-1:0]  d_d [STAGES];
  logic [CNT_W-1:0]  stall_q;
  logic [CNT_W-1:0]  stall_d;

  assign live = v_q & ~flush_mask;

  // Advance ripples from the output back; a running OR avoids a self-referencing vector.
  always_comb begin : adv_chain
    logic run;
    adv = '0;
    run = bus.out_ready;
    for (int k = STAGES - 1; k >= 0; k--) begin
      run    = run | ~live[k];
      adv[k] = run;
    end
  end

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    if (k == 0) begin : g_head
      assign v_d[k] = bus.in_valid & ~flush_mask[0];
      assign d_d[k] = bus.in_data;
    end else begin : g_body
      assign v_d[k] = live[k-1];
      assign d_d[k] = d_q[k-1];
    end

    pipe_stage #(.WIDTH(WIDTH)) u_stage (
      .clk    (clk),
      .rst_n  (rst_n),
      .load_i (adv[k]),
      .v_i    (v_d[k]),
      .d_i    (d_d[k]),
      .v_o    (v_q[k]),
      .d_o    (d_q[k])
    );
  end

  assign bus.in_ready  = adv[0];
  assign bus.out_valid = live[STAGES-1];
  assign bus.out_data  = d_q[STAGES-1];

  always_comb begin
    occupancy = '0;
    for (int k = 0; k < STAGES; k++) begin
      occupancy = occupancy + OCC_W'(v_q[k]);
    end
  end

  always_comb begin
    stall_d = stall_q;
    if (bus.out_valid && !bus.out_ready && (stall_q != {CNT_W{1'b1}})) begin
      stall_d = stall_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) stall_q <= '0;
    else        stall_q <= stall_d;
  end

  assign stall_cnt = stall_q;
endmodule
